fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that produces the 16-bit instruction words consumed by the instruction decoder. It owns the PC, issues one request at a time to instruction memory, buffers the returned word, and presents it to decode with a valid/ready handshake. It applies branch/jump redirects from execute and stops fetching after handing off a HALT opcode.

## Interface

Parameters:
- `PC_W`, 16, PC and instruction-memory address width.
- `INSTR_W`, 16, instruction width.
- `RESET_PC`, 16'h0000, PC loaded at reset; bit 0 must be 0.

Ports:
- `clk`, in, 1, sole clock; all state changes on the rising edge.
- `rst_n`, in, 1, synchronous active-low reset.
- `imem_req_valid`, out, 1, fetch request valid.
- `imem_req_ready`, in, 1, memory accepts the request.
- `imem_req_addr`, out, PC_W, fetch address, always even.
- `imem_rsp_valid`, in, 1, response word valid; one response per accepted request.
- `imem_rsp_data`, in, INSTR_W, response word.
- `dec_valid`, out, 1, `dec_instr` holds a valid instruction.
- `dec_ready`, in, 1, decode accepts the instruction.
- `dec_instr`, out, INSTR_W, instruction to decode; `[15:11]` is the opcode.
- `dec_pc`, out, PC_W, address of `dec_instr`.
- `dec_pc_plus2`, out, PC_W, `dec_pc + 2`, used for link/branch targets.
- `redirect_valid`, in, 1, execute redirects the fetch stream.
- `redirect_pc`, in, PC_W, redirect target; bit 0 is ignored and forced to 0.
- `halted`, out, 1, a HALT has been handed off and fetching has stopped.

## Operation

States are REQ, WAIT, HOLD, DRAIN and HALTED.
- **Reset:** state REQ; `pc = RESET_PC`; `imem_req_valid = 0`, `dec_valid = 0`, `halted = 0`; `dec_instr`, `dec_pc` and `dec_pc_plus2` are all 0. `imem_req_valid` rises on the first cycle after reset is released.
- **REQ:** `imem_req_valid = 1`, `imem_req_addr = pc`. On `imem_req_ready` the next state is WAIT.
- **WAIT:** on `imem_rsp_valid`:
  - the buffer captures data, `pc` and `pc + 2`;
  - `pc <= pc + 2`, wrapping modulo 2^PC_W (16'hFFFE -> 16'h0000);
  - the next state is HOLD.
- **HOLD:** `dec_valid = 1`, and the outputs stay stable until handoff. Handoff is `dec_valid && dec_ready && !redirect_valid`:
  - if `dec_instr[15:11] == 5'b00000`, the next state is HALTED;
  - otherwise the next state is REQ.
- **HALTED:** all valids are 0 and `halted = 1`. `redirect_valid` is ignored. The state is exited only by reset.
- **DRAIN:** waits for the response to a squashed request. The next `imem_rsp_valid` is discarded, then the next state is REQ.

Redirect (`redirect_valid = 1`, any state except HALTED): `pc <= {redirect_pc[PC_W-1:1], 1'b0}`.
- In REQ without ready, and in HOLD, the next state is REQ. In HOLD the buffered instruction is dropped and is not counted as accepted, even if `dec_ready = 1`.
- In REQ with ready (the request was accepted with the old pc), in WAIT without a response, and in DRAIN, the next state is DRAIN.
- In WAIT with `imem_rsp_valid` in the same cycle, the response is discarded and the next state is REQ.
- Redirect has priority over handoff and over response capture.

At most one memory request is outstanding at any time.

## Timing

- Request to accept: `imem_req_valid` is held until `imem_req_ready`; `imem_req_addr` is stable while valid.
- Responses are sampled only in WAIT and DRAIN, no earlier than the cycle after acceptance.
- Response to `dec_valid`: 1 cycle. `dec_valid` is registered, with no combinational path from any input.
- Best-case throughput with single-cycle memory and `dec_ready` tied high: one instruction every 3 cycles (REQ, WAIT, HOLD).
- `redirect_valid` is a one-cycle pulse. Its effect is visible on `imem_req_addr` within 1 cycle (direct to REQ) or after the drain response arrives.
- `rst_n` low in any state returns to the reset values on the next edge. Any response still in flight after reset must not be delivered by the memory model.

## Structure

- Package `fetch_pkg`:
  - `fetch_state_t` enum (REQ, WAIT, HOLD, DRAIN, HALTED);
  - `HALT_OPCODE = 5'b00000`;
  - `PC_INC = 2`;
  - `OPC_MSB = 15`, `OPC_LSB = 11`.
- Sub-module `fetch_hold_buf`: a single-entry register holding instr/pc/pc_plus2 with load and clear. The top level contains the FSM and the PC register.

## Test plan

- **Reset and straight-line fetch:** release reset with a 1-cycle memory and `dec_ready = 1`. Expect requested addresses 0x0000, 0x0002, 0x0004 and matching `dec_pc`, with `dec_pc_plus2` = `dec_pc + 2`.
- **Decode backpressure:** hold `dec_ready = 0` for 5 cycles in HOLD. `dec_instr` and `dec_pc` stay stable, and no new request is issued.
- **Redirect in WAIT with a 3-cycle memory:** the old response is discarded (`dec_valid` stays 0). The next request is to 0x0040 when `redirect_pc = 0x0041`.
- **Redirect in HOLD with `dec_ready = 1` in the same cycle:** the instruction is not handed off, and the next request address is the target.
- **HALT handoff:** an instruction 0x0000 at 0x0006 is accepted, then `halted = 1`, and there are no further requests even with `redirect_valid` pulsed. Asserting `rst_n = 0` restores a request to 0x0000.
- **PC wrap:** `redirect_pc = 0xFFFE`, then the next fetch is at 0x0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, the HALT opcode and the opcode field position.
// Imported by the fetch top level and its hold buffer.
package fetch_pkg;

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_t;

  localparam logic [4:0] HALT_OPCODE = 5'b00000;
  localparam int         PC_INC      = 2;
  localparam int         OPC_MSB     = 15;
  localparam int         OPC_LSB     = 11;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry holding register for the fetched instruction, its pc and pc+2.
// Latency: loaded value visible on the cycle after load.
// Backpressure: contents are held until the next load or clear.
module fetch_hold_buf
  import fetch_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [PC_W-1:0]    load_pc,
  input  logic [PC_W-1:0]    load_pc_plus2,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus2
);

  // Capture a returned word with its address; clear drops a squashed entry.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      instr    <= '0;
      pc       <= '0;
      pc_plus2 <= '0;
    end else if (load) begin
      instr    <= load_instr;
      pc       <= load_pc;
      pc_plus2 <= load_pc_plus2;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, one outstanding imem request, hands words to decode.
// Latency: memory response to dec_valid is one cycle; best case one instruction per 3 cycles.
// Backpressure: a held instruction waits for dec_ready; no new request is issued meanwhile.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  output logic [PC_W-1:0]    dec_pc_plus2,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
);

  fetch_state_t    state;
  fetch_state_t    nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_plus2;
  logic [PC_W-1:0] redirect_target;
  logic            req_accept;
  logic            handoff;
  logic            is_halt;
  logic            buf_load;
  logic            buf_clear;

  assign pc_plus2        = pc + PC_W'(PC_INC);
  assign redirect_target = redirect_pc & ~PC_W'(1);
  assign req_accept      = imem_req_valid && imem_req_ready;
  assign handoff         = dec_valid && dec_ready && !redirect_valid;
  assign is_halt         = (dec_instr[OPC_MSB:OPC_LSB] == HALT_OPCODE);
  assign imem_req_addr   = pc;

  // Next-state, next-pc and hold-buffer control; redirect outranks capture and handoff.
  always_comb begin
    nxt       = state;
    pc_nxt    = pc;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      REQ: begin
        if (redirect_valid) begin
          pc_nxt = redirect_target;
          // An accepted request still owes us a response that must be thrown away.
          nxt    = req_accept ? DRAIN : REQ;
        end else if (req_accept) begin
          nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_target;
          nxt    = imem_rsp_valid ? REQ : DRAIN;
        end else if (imem_rsp_valid) begin
          buf_load = 1'b1;
          pc_nxt   = pc_plus2;
          nxt      = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_target;
          buf_clear = 1'b1;
          nxt       = REQ;
        end else if (handoff) begin
          nxt = is_halt ? HALTED : REQ;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          pc_nxt = redirect_target;
        end
        // The stale response leaves the pipe; a redirect landing with it just updates pc.
        if (imem_rsp_valid) begin
          nxt = REQ;
        end
      end
      HALTED:  nxt = HALTED;
      default: nxt = REQ;
    endcase
  end

  // State, pc and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= REQ;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      dec_valid      <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= nxt;
      pc             <= pc_nxt;
      imem_req_valid <= (nxt == REQ);
      dec_valid      <= (nxt == HOLD);
      halted         <= (nxt == HALTED);
    end
  end

  fetch_hold_buf #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_hold_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (buf_load),
    .clear         (buf_clear),
    .load_instr    (imem_rsp_data),
    .load_pc       (pc),
    .load_pc_plus2 (pc_plus2),
    .instr         (dec_instr),
    .pc            (dec_pc),
    .pc_plus2      (dec_pc_plus2)
  );

endmodule
